bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side streaming engine for the team's simple dual-port M20K wrapper. Port B has a fixed 2-cycle read latency: registered address plus registered output.
- Accepts a burst command (base address, length) over valid/ready, drives the RAM read address, and re-aligns returned words to the read latency.
- Presents the words as a valid/ready stream with a last flag. A small credit-managed output FIFO absorbs downstream backpressure.
- Sits between any BRAM buffer (weights, activations) and its consumer datapath.

Parameters:
- DATAW, 32, data word width; must match the attached RAM.
- DEPTH, 512, number of RAM words.
- ADDRW, $clog2(DEPTH), RAM address width.
- RD_LATENCY, 2, RAM read latency in cycles; must be ≥1.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥ RD_LATENCY+1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_base  input  ADDRW  first word address.
- cmd_len  input  ADDRW+1  word count; range 0..DEPTH.
- bram_rdaddress  output  ADDRW  to RAM read address.
- bram_rden  output  1  read issued this cycle; used for debug and latency tracking, the RAM read is always enabled.
- bram_q  input  DATAW  RAM read data.
- o_valid  output  1  stream valid.
- o_ready  input  1  stream ready.
- o_data  output  DATAW  stream data.
- o_last  output  1  last word of current command.
- busy  output  1  command in progress, or data in flight or in the FIFO.

Behaviour:
- Reset (rst_n=0 at an edge):
  - Drives state to IDLE, all counters to 0, the latency valid pipe to 0 and the FIFO to empty.
  - Outputs: cmd_ready=0 during reset, o_valid=0, o_last=0, bram_rden=0, busy=0, bram_rdaddress=0, o_data=0.
  - Reset mid-burst discards all in-flight and buffered words; no partial output after reset release.
- States:
  - IDLE: cmd_ready=1. On accept with cmd_len>0: latch address←cmd_base, remaining←cmd_len, go to ISSUE. On accept with cmd_len=0: no reads, no output, stay IDLE.
  - ISSUE: cmd_ready=0. Issue one read in each cycle where credit is available; otherwise stall.
    - Credit: outstanding + fifo_count < FIFO_DEPTH, where outstanding is the number of valid bits in the latency pipe.
    - On issue: bram_rden=1; bram_rdaddress=address (registered state, not combinational from cmd_*); address←address+1 modulo DEPTH (wraps DEPTH-1 → 0); remaining←remaining−1.
    - The issue with remaining==1 tags last=1 and transitions to DRAIN.
  - DRAIN: cmd_ready=0. Go to IDLE when the latency pipe and the FIFO are both empty and the last word has been accepted downstream. The next command cannot be accepted in the same cycle as the exit.
- Latency alignment:
  - A RD_LATENCY-deep shift register carries {valid, last} per issued read.
  - At pipe exit, bram_q is written into the FIFO together with its last tag.
  - Command accepted at edge T: first bram_rden is in cycle T+1. bram_q is valid in cycle T+1+RD_LATENCY and is written at that edge. o_valid=1 earliest in cycle T+2+RD_LATENCY (T+4 by default).
  - With o_ready held high: one word per cycle sustained, no bubbles.
- FIFO:
  - Show-ahead; o_data and o_last are driven from the FIFO head.
  - Simultaneous write and pop are allowed in the same cycle, including when full.
  - Overflow is impossible by construction of the credit check. An assertion must fire if a write reaches a full FIFO without a pop.
- Handshake:
  - o_valid, once high, stays high with o_data and o_last stable until o_ready=1.
  - cmd_* inputs are sampled only on accept.
- busy = (state≠IDLE) or pipe nonempty or FIFO nonempty.
- Width rules: remaining is ADDRW+1 bits. cmd_len>DEPTH is illegal; it is covered by an assertion, and the behaviour is the value truncated to ADDRW+1 bits.

Test Plan:
1. Reset, then cmd base=0 len=8, RAM preloaded with word[i]=i+100, o_ready=1 → o_valid first high 4 cycles after accept. o_data = 100..107 on consecutive cycles, o_last only on 107, busy falls after that, cmd_ready back at 1.
2. Wrap-around: base=510 len=4 with DEPTH=512 → bram_rdaddress sequence 510, 511, 0, 1; o_data = word[510], word[511], word[0], word[1].
3. Backpressure: len=16, o_ready toggled 1-0-0-1 repeating → bram_rden stalls whenever outstanding+fifo_count=4. No word lost or duplicated; order preserved; o_data stable while stalled.
4. len=0 command → accepted in one cycle, zero bram_rden, zero o_valid. A following len=1 base=5 command → single word[5] with o_last=1.
5. Reset mid-burst: len=32, rst_n=0 for 1 cycle after 10 words output → o_valid=0 the cycle after reset, busy=0, FIFO empty. A new cmd base=0 len=2 produces exactly word[0], word[1].
6. Back-to-back commands: len=1 then len=1 presented continuously → second accept occurs only after DRAIN exits. Outputs are 2 words, each with o_last=1.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command, RAM read port and output stream
// bundle shared by the BRAM streaming reader and its environment.
interface bram_stream_reader_if #(
   parameter int DATAW = 32,
   parameter int ADDRW = 9
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [ADDRW-1:0] cmd_base;
   logic [ADDRW:0]   cmd_len;
   logic [ADDRW-1:0] bram_rdaddress;
   logic             bram_rden;
   logic [DATAW-1:0] bram_q;
   logic             o_valid;
   logic             o_ready;
   logic [DATAW-1:0] o_data;
   logic             o_last;
   logic             busy;

   modport master (
      input  cmd_valid, cmd_base, cmd_len, bram_q, o_ready,
      output cmd_ready, bram_rdaddress, bram_rden,
      output o_valid, o_data, o_last, busy
   );

   modport slave (
      output cmd_valid, cmd_base, cmd_len, bram_q, o_ready,
      input  cmd_ready, bram_rdaddress, bram_rden,
      input  o_valid, o_data, o_last, busy
   );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: burst read engine for a fixed-latency BRAM port,
// re-aligning returned words into a credit-managed show-ahead FIFO.
module bram_stream_reader #(
   parameter int DATAW      = 32,
   parameter int DEPTH      = 512,
   parameter int ADDRW      = $clog2(DEPTH),
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   bram_stream_reader_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 2;
   localparam logic [ADDRW-1:0] A_LAST  = ADDRW'(DEPTH - 1);
   localparam logic [ADDRW:0]   LEN_MAX = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW:0]   LEN_ONE = (ADDRW+1)'(1);
   localparam logic [CW-1:0]    F_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_e;

   state_e                state_q, state_d;
   logic [ADDRW-1:0]      addr_q, addr_d;
   logic [ADDRW:0]        rem_q, rem_d;
   logic [RD_LATENCY-1:0] pv_q, pv_d;
   logic [RD_LATENCY-1:0] pl_q, pl_d;
   logic [DATAW-1:0]      mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] ml_q;
   logic [PW-1:0]         wp_q, rp_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         outst;
   logic                  credit;
   logic                  issue;
   logic                  tag_last;
   logic                  accept;
   logic                  fifo_wr;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pipe_empty;

   // Credit counts reads in flight plus words parked in the FIFO,
   // so a read is only issued when its word is guaranteed a slot.
   assign outst      = CW'($countones(pv_q));
   assign credit     = (outst + cnt_q) < F_FULL;
   assign pipe_empty = (pv_q == '0);
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == F_FULL);
   assign fifo_wr    = pv_q[RD_LATENCY-1];
   assign fifo_pop   = bus.o_valid && bus.o_ready;
   assign cnt_d      = cnt_q + CW'(fifo_wr) - CW'(fifo_pop);
   assign accept     = bus.cmd_valid && bus.cmd_ready;

   assign bus.cmd_ready      = rst_n && (state_q == IDLE);
   assign bus.bram_rden      = rst_n && issue;
   assign bus.bram_rdaddress = rst_n ? addr_q : '0;
   assign bus.o_valid        = rst_n && !fifo_empty;
   assign bus.o_data         = (rst_n && !fifo_empty) ? mem_q[rp_q] : '0;
   assign bus.o_last         = rst_n && !fifo_empty && ml_q[rp_q];
   assign bus.busy           = rst_n && ((state_q != IDLE) ||
                                         !pipe_empty || !fifo_empty);

   // Next-state decode: command accept, read issue and drain exit
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      issue    = 1'b0;
      tag_last = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid && bus.cmd_len != '0) begin
               addr_d  = bus.cmd_base;
               rem_d   = bus.cmd_len;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (credit) begin
               issue  = 1'b1;
               addr_d = (addr_q == A_LAST) ? '0 : addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == LEN_ONE) begin
                  tag_last = 1'b1;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pipe_empty && fifo_empty) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Latency pipe shifts {valid, last} one stage per cycle
   always_comb begin
      pv_d    = '0;
      pl_d    = '0;
      pv_d[0] = issue;
      pl_d[0] = tag_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pv_d[i] = pv_q[i-1];
         pl_d[i] = pl_q[i-1];
      end
   end

   // Control state, read address and remaining word count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
      end
   end

   // Latency pipe and FIFO pointers; reset drops all in-flight words
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pv_q  <= '0;
         pl_q  <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         pv_q  <= pv_d;
         pl_q  <= pl_d;
         cnt_q <= cnt_d;
         if (fifo_wr) begin
            wp_q <= wp_q + 1'b1;
         end
         if (fifo_pop) begin
            rp_q <= rp_q + 1'b1;
         end
      end
   end

   // FIFO storage captures RAM data as the pipe slot exits
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem_q[wp_q] <= bus.bram_q;
         ml_q[wp_q]  <= pl_q[RD_LATENCY-1];
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_wr && fifo_full && !fifo_pop))
      else $error("write into full FIFO without pop");

   a_len_range: assert property (@(posedge clk) disable iff (!rst_n)
      accept |-> (bus.cmd_len <= LEN_MAX))
      else $error("cmd_len exceeds DEPTH");
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed bursts against a queue-based model
// of the reader plus a 2-cycle RAM model.
module tb_bram_stream_reader;
   localparam int DW  = 32;
   localparam int DEP = 512;
   localparam int AW  = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bram_stream_reader_if #(.DATAW(DW), .ADDRW(AW)) bus ();

   bram_stream_reader #(
      .DATAW(DW), .DEPTH(DEP), .ADDRW(AW),
      .RD_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   logic [DW-1:0] ram [DEP];
   logic [AW-1:0] ra_q;

   // RAM: registered address then registered data
   always @(posedge clk) begin
      ra_q       <= bus.bram_rdaddress;
      bus.bram_q <= ram[ra_q];
   end

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } wd_t;

   int tot = 0;
   int bad = 0;
   wd_t exp_q[$];
   logic [AW-1:0] adq[$];
   logic [DW-1:0] got_d[$];
   logic got_l[$];
   int alog[$];
   int want_d[$];
   logic want_l[$];
   int inflight, max_infl, rden_tot, ov_tot;
   bit tail, hold, act, popd, poplast, toggle;
   logic [DW-1:0] hd;
   logic hl;
   wd_t w;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      tot++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, a, e);
      end
   endtask

   // Model and per-cycle compare
   initial begin
      inflight = 0;
      max_infl = 0;
      rden_tot = 0;
      ov_tot   = 0;
      tail     = 0;
      hold     = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            adq.delete();
            inflight = 0;
            tail = 0;
            hold = 0;
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("rst_o_valid", 32'(bus.o_valid), 0);
            chk("rst_o_last", 32'(bus.o_last), 0);
            chk("rst_rden", 32'(bus.bram_rden), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_rdaddr", 32'(bus.bram_rdaddress), 0);
            chk("rst_o_data", bus.o_data, 0);
         end else begin
            act = (exp_q.size() > 0) || tail;
            chk("busy", 32'(bus.busy), 32'(act));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(!act));
            if (hold) begin
               chk("hold_valid", 32'(bus.o_valid), 1);
               chk("hold_data", bus.o_data, hd);
               chk("hold_last", 32'(bus.o_last), 32'(hl));
            end
            popd = 0;
            poplast = 0;
            if (bus.o_valid) begin
               ov_tot++;
               chk("valid_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  chk("o_data", bus.o_data, exp_q[0].d);
                  chk("o_last", 32'(bus.o_last), 32'(exp_q[0].l));
                  if (bus.o_ready) begin
                     popd = 1;
                     poplast = exp_q[0].l;
                     got_d.push_back(bus.o_data);
                     got_l.push_back(bus.o_last);
                     void'(exp_q.pop_front());
                  end
               end
            end
            hold = bus.o_valid && !bus.o_ready;
            hd = bus.o_data;
            hl = bus.o_last;
            if (bus.bram_rden) begin
               rden_tot++;
               alog.push_back(int'(bus.bram_rdaddress));
               chk("credit", 32'(inflight < 4), 1);
               chk("rden_expected", 32'(adq.size() != 0), 1);
               if (adq.size() != 0) begin
                  chk("rdaddr", 32'(bus.bram_rdaddress), 32'(adq[0]));
                  void'(adq.pop_front());
               end
            end
            inflight = inflight + int'(bus.bram_rden) - int'(popd);
            if (inflight > max_infl) max_infl = inflight;
            tail = poplast;
            if (bus.cmd_valid && bus.cmd_ready) begin
               for (int i = 0; i < int'(bus.cmd_len); i++) begin
                  int a;
                  a = (int'(bus.cmd_base) + i) % DEP;
                  w.d = ram[a];
                  w.l = (i == int'(bus.cmd_len) - 1);
                  exp_q.push_back(w);
                  adq.push_back(AW'(a));
               end
            end
         end
      end
   end

   // Downstream ready: constant high, or 1-0-0-1 pattern
   initial begin
      bit pat [4];
      int k;
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
      k = 0;
      bus.o_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (toggle) begin
            bus.o_ready = pat[k];
            k = (k + 1) % 4;
         end else begin
            bus.o_ready = 1'b1;
            k = 0;
         end
      end
   end

   task automatic send_cmd(input int b, input int l, input bit keep,
                           output int waited);
      bit r;
      bus.cmd_base  = AW'(b);
      bus.cmd_len   = (AW+1)'(l);
      bus.cmd_valid = 1'b1;
      waited = 0;
      r = 0;
      while (!r && waited < 300) begin
         @(negedge clk);
         r = bus.cmd_ready;
         @(posedge clk);
         waited++;
      end
      chk("cmd_accepted", 32'(r), 1);
      #1;
      if (!keep) bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (k < 400 && !(bus.cmd_ready && !bus.busy));
      chk(nm, 32'(k < 400), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic want_run(input int first, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         want_d.push_back(first + i);
         want_l.push_back(i == cnt - 1);
      end
   endtask

   task automatic chk_got(input string nm);
      chk({nm, "_count"}, got_d.size(), want_d.size());
      for (int i = 0; i < want_d.size() && i < got_d.size(); i++) begin
         chk({nm, "_data"}, got_d[i], want_d[i]);
         chk({nm, "_last"}, 32'(got_l[i]), 32'(want_l[i]));
      end
      got_d.delete();
      got_l.delete();
      want_d.delete();
      want_l.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      int wt, n, r0, v0, k;
      bit seen;
      for (int i = 0; i < DEP; i++) ram[i] = DW'(i + 100);
      toggle = 0;
      bus.cmd_valid = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: basic burst, latency and no bubbles
      send_cmd(0, 8, 0, wt);
      n = 0;
      seen = 0;
      for (int k2 = 1; k2 <= 20 && !seen; k2++) begin
         @(negedge clk);
         if (bus.o_valid) begin
            seen = 1;
            n = k2;
         end
      end
      chk("t1_latency", n, 4);
      repeat (7) begin
         @(negedge clk);
         chk("t1_nobubble", 32'(bus.o_valid), 1);
      end
      wait_idle("t1_idle");
      want_run(100, 8);
      chk_got("t1");

      // 2: address wrap
      alog.delete();
      send_cmd(510, 4, 0, wt);
      wait_idle("t2_idle");
      chk("t2_naddr", alog.size(), 4);
      if (alog.size() == 4) begin
         chk("t2_a0", alog[0], 510);
         chk("t2_a1", alog[1], 511);
         chk("t2_a2", alog[2], 0);
         chk("t2_a3", alog[3], 1);
      end
      want_run(610, 2);
      want_run(100, 2);
      want_l[1] = 0;
      chk_got("t2");

      // 3: backpressure
      max_infl = 0;
      toggle = 1;
      send_cmd(20, 16, 0, wt);
      wait_idle("t3_idle");
      toggle = 0;
      chk("t3_stall", max_infl, 4);
      want_run(120, 16);
      chk_got("t3");

      // 4: zero-length then single word
      r0 = rden_tot;
      v0 = ov_tot;
      send_cmd(0, 0, 0, wt);
      chk("t4_accept", wt, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("t4_rden", rden_tot, r0);
      chk("t4_valid", ov_tot, v0);
      send_cmd(5, 1, 0, wt);
      wait_idle("t4_idle");
      want_run(105, 1);
      chk_got("t4");

      // 5: reset mid-burst
      send_cmd(0, 32, 0, wt);
      k = 0;
      while (got_d.size() < 10 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t5_reached10", 32'(got_d.size() >= 10), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t5_valid", 32'(bus.o_valid), 0);
      chk("t5_busy", 32'(bus.busy), 0);
      repeat (5) begin
         @(negedge clk);
         chk("t5_quiet", 32'(bus.o_valid), 0);
      end
      @(posedge clk);
      #1;
      got_d.delete();
      got_l.delete();
      send_cmd(0, 2, 0, wt);
      wait_idle("t5_idle");
      want_run(100, 2);
      chk_got("t5");

      // 6: back-to-back single-word commands
      send_cmd(3, 1, 1, wt);
      send_cmd(4, 1, 0, wt);
      chk("t6_gap", wt, 6);
      wait_idle("t6_idle");
      want_run(103, 1);
      want_run(104, 1);
      chk_got("t6");

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
